// File: rtl/seq_binary_to_bcd.sv
// seq_binary_to_bcd: sequential binary to BCD converter (double-dabble).
// One shift per clock; the result and a leading-zero blanking mask are
// registered and held until the next conversion completes.
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : conversion request, accepted only in IDLE
//   bin      : unsigned binary input, captured on the accepting edge
//   busy     : high whenever the FSM is not in IDLE
//   done     : one-cycle pulse, new result valid on bcd/digit_en
//   bcd      : DIGITS packed BCD digits, digit 0 (ones) in bits [3:0]
//   digit_en : digit i enabled if it or any higher digit is nonzero; bit 0 always set
module seq_binary_to_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_sr;
  logic [4*DIGITS-1:0] r_scr;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [4*DIGITS-1:0] r_bcd;
  logic [DIGITS-1:0]   r_en;

  logic [4*DIGITS-1:0] w_adj;
  logic [4*DIGITS-1:0] w_scr_nxt;
  logic [WIDTH-1:0]    w_sr_nxt;
  logic [DIGITS-1:0]   w_en_nxt;
  logic                w_nz;

  // One double-dabble step: add-3 correction, then shift {scratch, sr} left.
  // The blanking mask is derived from the post-shift scratch so the final
  // step can load bcd and digit_en on the same edge it enters DONE.
  always_comb begin
    w_adj = r_scr;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scr[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
    end
    w_scr_nxt = {w_adj[4*DIGITS-2:0], r_sr[WIDTH-1]};
    w_sr_nxt  = {r_sr[WIDTH-2:0], 1'b0};

    w_nz     = 1'b0;
    w_en_nxt = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_nz        = w_nz | (w_scr_nxt[4*i +: 4] != 4'd0);
      w_en_nxt[i] = w_nz;
    end
    w_en_nxt[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
      r_en    <= {{(DIGITS-1){1'b0}}, 1'b1};
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sr    <= bin;
            r_scr   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_sr  <= w_sr_nxt;
          r_scr <= w_scr_nxt;
          if (r_cnt == CW'(WIDTH - 1)) begin
            // Last of WIDTH shifts: publish the result directly.
            r_bcd   <= w_scr_nxt;
            r_en    <= w_en_nxt;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign digit_en = r_en;

endmodule
